// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if
//   Word handshake, configuration and result bundle for seq_detect_ctrl.
//   master : word producer / result consumer (drives cfg_*, in_valid, in_word, in_last)
//   slave  : seq_detect_ctrl (drives in_ready, ser_bit, match, match_count, busy, done)
//   Signals:
//     cfg_pattern [PAT_W] pattern to detect, MSB = first bit in time
//     cfg_overlap         1 = overlapping matches counted
//     in_valid / in_ready word handshake
//     in_word [WORD_W]    data word, shifted out MSB first
//     in_last             marks final word of a frame
//     ser_bit             bit most recently shifted into the detector
//     match               one-cycle pulse per detected pattern
//     match_count [CNT_W] matches in current/last frame
//     busy                controller not idle
//     done                one-cycle pulse at frame completion
interface seq_detect_ctrl_if #(
   parameter int WORD_W = 8,
   parameter int PAT_W  = 4,
   parameter int CNT_W  = 8
);
   logic [PAT_W-1:0]  cfg_pattern;
   logic              cfg_overlap;
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_word;
   logic              in_last;
   logic              ser_bit;
   logic              match;
   logic [CNT_W-1:0]  match_count;
   logic              busy;
   logic              done;

   modport master (
      output cfg_pattern, cfg_overlap, in_valid, in_word, in_last,
      input  in_ready, ser_bit, match, match_count, busy, done
   );

   modport slave (
      input  cfg_pattern, cfg_overlap, in_valid, in_word, in_last,
      output in_ready, ser_bit, match, match_count, busy, done
   );
endinterface

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Frame-level controller for a serial pattern detector. Accepts words over a
//   valid/ready handshake, serializes them MSB first into a Moore detector with
//   a programmable pattern and counts matches over a frame, including matches
//   that span word boundaries. A done pulse marks the end of each frame.
//   Ports:
//     clock : system clock, rising edge
//     reset : synchronous active-low reset
//     bus   : seq_detect_ctrl_if.slave (handshake, configuration, results)
//   Build option:
//     SEQ_DETECT_CTRL_SAT_EN defined   -> match_count saturates at all-ones
//     SEQ_DETECT_CTRL_SAT_EN undefined -> match_count wraps modulo 2^CNT_W
module seq_detect_ctrl #(
   parameter int WORD_W = 8,
   parameter int PAT_W  = 4,
   parameter int CNT_W  = 8
) (
   input logic               clock,
   input logic               reset,
   seq_detect_ctrl_if.slave  bus
);

   localparam int FW = $clog2(PAT_W + 1);
   localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state;
   logic [WORD_W-1:0] shreg;
   logic [PAT_W-1:0]  history;
   logic [PAT_W-1:0]  pat_q;
   logic              ovl_q;
   logic [FW-1:0]     fill;
   logic [IW-1:0]     bit_idx;
   logic              last_q;
   logic              frame_open;
   logic              ser_q;
   logic              match_q;
   logic              done_q;
   logic [CNT_W-1:0]  count_q;

   logic              cur_bit;
   logic [PAT_W-1:0]  hist_nx;
   logic [FW-1:0]     fill_inc;
   logic [FW-1:0]     fill_nx;
   logic              hit;
   logic [CNT_W-1:0]  count_nx;

   // Detector next-state: the window is only valid once PAT_W bits have been
   // seen since frame start (or since the last hit in non-overlap mode).
   always_comb begin
      cur_bit  = shreg[WORD_W-1];
      hist_nx  = {history[PAT_W-2:0], cur_bit};
      fill_inc = (fill == FW'(PAT_W)) ? fill : fill + 1'b1;
      hit      = (fill_inc == FW'(PAT_W)) && (hist_nx == pat_q);
      fill_nx  = (hit && !ovl_q) ? '0 : fill_inc;
`ifdef SEQ_DETECT_CTRL_SAT_EN
      count_nx = (count_q == '1) ? count_q : count_q + 1'b1;
`else
      count_nx = count_q + 1'b1;
`endif
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         shreg      <= '0;
         history    <= '0;
         pat_q      <= '0;
         ovl_q      <= 1'b0;
         fill       <= '0;
         bit_idx    <= '0;
         last_q     <= 1'b0;
         frame_open <= 1'b0;
         ser_q      <= 1'b0;
         match_q    <= 1'b0;
         done_q     <= 1'b0;
         count_q    <= '0;
      end else begin
         match_q <= 1'b0;
         done_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  shreg   <= bus.in_word;
                  last_q  <= bus.in_last;
                  bit_idx <= '0;
                  state   <= SHIFT;
                  // First word of a frame: configuration is frozen here and
                  // the detector window starts empty.
                  if (!frame_open) begin
                     pat_q      <= bus.cfg_pattern;
                     ovl_q      <= bus.cfg_overlap;
                     history    <= '0;
                     fill       <= '0;
                     count_q    <= '0;
                     frame_open <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               shreg   <= {shreg[WORD_W-2:0], 1'b0};
               ser_q   <= cur_bit;
               history <= hist_nx;
               fill    <= fill_nx;
               match_q <= hit;
               if (hit) count_q <= count_nx;
               bit_idx <= bit_idx + 1'b1;
               if (bit_idx == IW'(WORD_W - 1)) begin
                  if (last_q) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DONE: begin
               frame_open <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready    = reset && (state == IDLE);
   assign bus.busy        = (state != IDLE);
   assign bus.ser_bit     = ser_q;
   assign bus.match       = match_q;
   assign bus.done        = done_q;
   assign bus.match_count = count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl
//   Bench for seq_detect_ctrl: a CNT_W=8 instance and a CNT_W=2 instance share
//   the same stimulus. Every cycle's outputs are recorded; expected values come
//   from a window-matching model over the bit stream of each frame.
module tb_seq_detect_ctrl;

   localparam int PW   = 4;
   localparam int MAXC = 4096;

   logic clock = 1'b0;
   logic reset = 1'b0;

   seq_detect_ctrl_if #(.WORD_W(8), .PAT_W(4), .CNT_W(8)) bus ();
   seq_detect_ctrl_if #(.WORD_W(8), .PAT_W(4), .CNT_W(2)) bus2 ();

   assign bus2.cfg_pattern = bus.cfg_pattern;
   assign bus2.cfg_overlap = bus.cfg_overlap;
   assign bus2.in_valid    = bus.in_valid;
   assign bus2.in_word     = bus.in_word;
   assign bus2.in_last     = bus.in_last;

   seq_detect_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   seq_detect_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(2)) dut2 (
      .clock (clock),
      .reset (reset),
      .bus   (bus2.slave)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Observed outputs per cycle
   logic       s_match [0:MAXC-1];
   logic       s_done  [0:MAXC-1];
   logic       s_ser   [0:MAXC-1];
   logic       s_ready [0:MAXC-1];
   logic       s_busy  [0:MAXC-1];
   logic [7:0] s_cnt   [0:MAXC-1];
   logic [1:0] s2_cnt  [0:MAXC-1];

   // Expected outputs per cycle
   logic       e_match [0:MAXC-1];
   logic       e_done  [0:MAXC-1];
   logic       e_ser   [0:MAXC-1];
   logic       e_sv    [0:MAXC-1];
   logic       e_ready [0:MAXC-1];
   int         e_cnt   [0:MAXC-1];

   // Accepted words and their accept cycles
   int         fr_acc  [$];
   logic [7:0] fr_word [$];

   function automatic logic [7:0] exp_cnt(input int h);
      return 8'(h % 256);
   endfunction

   function automatic logic [1:0] exp_cnt2(input int h);
`ifdef SEQ_DETECT_CTRL_SAT_EN
      return (h > 3) ? 2'd3 : 2'(h);
`else
      return 2'(h % 4);
`endif
   endfunction

   // One cycle: wait for the falling edge, record all outputs of that cycle.
   task automatic tick();
      @(negedge clock);
      cyc++;
      if (cyc >= MAXC) begin
         n_fail++;
         $display("FAIL cycle_budget: reached %0d cycles, limit %0d", cyc, MAXC);
         $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
         $fatal(1);
      end
      s_match[cyc] = bus.match;
      s_done[cyc]  = bus.done;
      s_ser[cyc]   = bus.ser_bit;
      s_ready[cyc] = bus.in_ready;
      s_busy[cyc]  = bus.busy;
      s_cnt[cyc]   = bus.match_count;
      s2_cnt[cyc]  = bus2.match_count;
   endtask

   task automatic flush(input int n);
      repeat (n) begin
         tick();
         bus.in_valid = 1'b0;
      end
   endtask

   // Holds in_valid low for `hold` cycles, then presents the word until the
   // controller is ready. While not ready, in_word/in_last are scrambled so a
   // stray capture shows up in ser_bit. Optionally scrambles cfg_* too.
   task automatic send_word(input logic [7:0] w, input logic last, input int hold,
                            input logic scramble_cfg);
      repeat (hold) begin
         tick();
         bus.in_valid = 1'b0;
         if (scramble_cfg) begin
            bus.cfg_pattern = 4'($urandom);
            bus.cfg_overlap = 1'($urandom);
         end
      end
      for (int n = 0; n < 40; n++) begin
         tick();
         if (scramble_cfg) begin
            bus.cfg_pattern = 4'($urandom);
            bus.cfg_overlap = 1'($urandom);
         end
         bus.in_valid = 1'b1;
         if (bus.in_ready === 1'b1) begin
            bus.in_word = w;
            bus.in_last = last;
            fr_acc.push_back(cyc);
            fr_word.push_back(w);
            return;
         end
         bus.in_word = 8'($urandom);
         bus.in_last = 1'($urandom);
      end
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: word %h not accepted within 40 cycles (cycle %0d)", w, cyc);
   endtask

   // Reference: scan the frame's bit stream; a match ends at bit n when the
   // last PW bits equal the pattern and, without overlap, at least PW bits
   // have passed since the previous match. Bit k of a word accepted in cycle
   // a is visible in cycle a+k+2; done appears 9 cycles after the last accept.
   function automatic void build_expect(input int first, input logic [3:0] pat,
                                        input logic ovl, output int d, output int h);
      logic       bits [$];
      logic [7:0] w;
      logic       b;
      logic       hit;
      int         last_hit;
      int         n;
      int         c;
      int         run;
      last_hit = -PW;
      h = 0;
      d = fr_acc[fr_acc.size()-1] + 9;
      for (int k = fr_acc[first]; k <= d + 2; k++) begin
         e_match[k] = 1'b0;
         e_done[k]  = 1'b0;
         e_ser[k]   = 1'b0;
         e_sv[k]    = 1'b0;
         e_ready[k] = 1'b1;
         e_cnt[k]   = 0;
      end
      for (int j = first; j < fr_acc.size(); j++) begin
         w = fr_word[j];
         for (int k = 1; k <= 8; k++) e_ready[fr_acc[j] + k] = 1'b0;
         for (int k = 0; k < 8; k++) begin
            b = w[7-k];
            bits.push_back(b);
            n = bits.size() - 1;
            hit = 1'b0;
            if (n >= PW - 1 && (ovl || (n - last_hit) >= PW)) begin
               hit = 1'b1;
               for (int t = 0; t < PW; t++)
                  if (bits[n-PW+1+t] !== pat[PW-1-t]) hit = 1'b0;
            end
            if (hit) begin
               h++;
               last_hit = n;
            end
            c = fr_acc[j] + k + 2;
            e_match[c] = hit;
            e_ser[c]   = b;
            e_sv[c]    = 1'b1;
         end
      end
      e_done[d]  = 1'b1;
      e_ready[d] = 1'b0;
      run = 0;
      for (int k = fr_acc[first] + 1; k <= d + 1; k++) begin
         if (e_match[k]) run++;
         e_cnt[k] = run;
      end
   endfunction

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         tick();
         n_chk++;
         if ({s_ready[cyc], s_busy[cyc], s_match[cyc], s_done[cyc], s_ser[cyc]} !== 5'b0 ||
             s_cnt[cyc] !== 8'd0 || s2_cnt[cyc] !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_hold cyc %0d: ready/busy/match/done/ser=%b%b%b%b%b cnt=%0d cnt2=%0d, want all 0",
                     cyc, s_ready[cyc], s_busy[cyc], s_match[cyc], s_done[cyc], s_ser[cyc],
                     s_cnt[cyc], s2_cnt[cyc]);
         end
      end
      reset = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      n_chk++;
      if (s_ready[cyc] !== 1'b1 || s_busy[cyc] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b busy=%b, want ready=1 busy=0",
                  s_ready[cyc], s_busy[cyc]);
      end
   endtask

   task automatic test_overlap();
      int first, d, h, a;
      for (int ov = 1; ov >= 0; ov--) begin
         bus.cfg_pattern = 4'b0101;
         bus.cfg_overlap = 1'(ov);
         first = fr_acc.size();
         send_word(8'h55, 1'b1, 0, 1'b0);
         flush(10);
         a = fr_acc[first];
         build_expect(first, 4'b0101, 1'(ov), d, h);
         for (int c = a + 1; c <= d + 1; c++) begin
            n_chk++;
            if ({s_match[c], s_done[c], s_ready[c], s_busy[c]} !== {e_match[c], e_done[c], e_ready[c], ~e_ready[c]} ||
                (e_sv[c] && s_ser[c] !== e_ser[c]) ||
                s_cnt[c] !== exp_cnt(e_cnt[c]) || s2_cnt[c] !== exp_cnt2(e_cnt[c])) begin
               n_fail++;
               $display("FAIL overlap%0d cyc %0d: m/d/r/b/ser/cnt/cnt2 = %b %b %b %b %b %0d %0d, want %b %b %b %b %b %0d %0d",
                        ov, c, s_match[c], s_done[c], s_ready[c], s_busy[c], s_ser[c], s_cnt[c], s2_cnt[c],
                        e_match[c], e_done[c], e_ready[c], ~e_ready[c], e_ser[c],
                        exp_cnt(e_cnt[c]), exp_cnt2(e_cnt[c]));
            end
         end
         n_chk++;
         if (s_done[a+9] !== 1'b1 || s_cnt[a+9] !== ((ov != 0) ? 8'd3 : 8'd2)) begin
            n_fail++;
            $display("FAIL overlap%0d_final: done=%b cnt=%0d at accept+9, want done=1 cnt=%0d",
                     ov, s_done[a+9], s_cnt[a+9], (ov != 0) ? 3 : 2);
         end
         n_chk++;
         if (s_match[a+7] !== 1'(ov)) begin
            n_fail++;
            $display("FAIL overlap%0d_mid: match at accept+7 = %b, want %b", ov, s_match[a+7], ov);
         end
      end
   endtask

   // Boundary-spanning match, first with in_valid held high, then with a
   // 5-cycle idle gap between the words.
   task automatic test_boundary_stall();
      int first, d, h, a, a2, hold;
      for (int v = 0; v < 2; v++) begin
         hold = (v == 0) ? 0 : 13;
         bus.cfg_pattern = 4'b0101;
         bus.cfg_overlap = 1'b1;
         first = fr_acc.size();
         send_word(8'h02, 1'b0, 0, 1'b0);
         send_word(8'h80, 1'b1, hold, 1'b0);
         flush(10);
         a  = fr_acc[first];
         a2 = fr_acc[first+1];
         build_expect(first, 4'b0101, 1'b1, d, h);
         for (int c = a + 1; c <= d + 1; c++) begin
            n_chk++;
            if ({s_match[c], s_done[c], s_ready[c], s_busy[c]} !== {e_match[c], e_done[c], e_ready[c], ~e_ready[c]} ||
                (e_sv[c] && s_ser[c] !== e_ser[c]) ||
                s_cnt[c] !== exp_cnt(e_cnt[c]) || s2_cnt[c] !== exp_cnt2(e_cnt[c])) begin
               n_fail++;
               $display("FAIL boundary%0d cyc %0d: m/d/r/b/ser/cnt/cnt2 = %b %b %b %b %b %0d %0d, want %b %b %b %b %b %0d %0d",
                        v, c, s_match[c], s_done[c], s_ready[c], s_busy[c], s_ser[c], s_cnt[c], s2_cnt[c],
                        e_match[c], e_done[c], e_ready[c], ~e_ready[c], e_ser[c],
                        exp_cnt(e_cnt[c]), exp_cnt2(e_cnt[c]));
            end
         end
         n_chk++;
         if (a2 - a !== ((v == 0) ? 9 : 14)) begin
            n_fail++;
            $display("FAIL boundary%0d_accept: second word accepted %0d cycles after first, want %0d",
                     v, a2 - a, (v == 0) ? 9 : 14);
         end
         n_chk++;
         if (s_match[a2+2] !== 1'b1 || s_cnt[d] !== 8'd1) begin
            n_fail++;
            $display("FAIL boundary%0d_hit: match at accept2+2 = %b, final cnt %0d, want 1 and 1",
                     v, s_match[a2+2], s_cnt[d]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int first, d, h, a;
      bus.cfg_pattern = 4'b0101;
      bus.cfg_overlap = 1'b1;
      send_word(8'h55, 1'b1, 0, 1'b0);
      a = fr_acc[fr_acc.size()-1];
      while (cyc < a + 6) begin
         tick();
         bus.in_valid = 1'b0;
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n_chk++;
      if ({s_ready[cyc], s_busy[cyc], s_match[cyc], s_done[cyc], s_ser[cyc]} !== 5'b0 || s_cnt[cyc] !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid_clear: ready/busy/match/done/ser=%b%b%b%b%b cnt=%0d, want all 0",
                  s_ready[cyc], s_busy[cyc], s_match[cyc], s_done[cyc], s_ser[cyc], s_cnt[cyc]);
      end
      first = fr_acc.size();
      send_word(8'h80, 1'b1, 0, 1'b0);
      flush(10);
      for (int c = a + 7; c <= fr_acc[first]; c++) begin
         n_chk++;
         if (s_done[c] !== 1'b0 || s_match[c] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_gap cyc %0d: done=%b match=%b, want 0 0", c, s_done[c], s_match[c]);
         end
      end
      build_expect(first, 4'b0101, 1'b1, d, h);
      for (int c = fr_acc[first] + 1; c <= d + 1; c++) begin
         n_chk++;
         if ({s_match[c], s_done[c], s_ready[c], s_busy[c]} !== {e_match[c], e_done[c], e_ready[c], ~e_ready[c]} ||
             (e_sv[c] && s_ser[c] !== e_ser[c]) ||
             s_cnt[c] !== exp_cnt(e_cnt[c]) || s2_cnt[c] !== exp_cnt2(e_cnt[c])) begin
            n_fail++;
            $display("FAIL reset_mid cyc %0d: m/d/r/b/ser/cnt/cnt2 = %b %b %b %b %b %0d %0d, want %b %b %b %b %b %0d %0d",
                     c, s_match[c], s_done[c], s_ready[c], s_busy[c], s_ser[c], s_cnt[c], s2_cnt[c],
                     e_match[c], e_done[c], e_ready[c], ~e_ready[c], e_ser[c],
                     exp_cnt(e_cnt[c]), exp_cnt2(e_cnt[c]));
         end
      end
      n_chk++;
      if (s_done[d] !== 1'b1 || s_cnt[d] !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid_final: done=%b cnt=%0d, want done=1 cnt=0", s_done[d], s_cnt[d]);
      end
   endtask

   // Counter width limit on the CNT_W=2 instance: 7 matches and 5 matches.
   task automatic test_wrap();
      int first, d, h;
      logic [7:0] w2;
      for (int v = 0; v < 2; v++) begin
         w2 = (v == 0) ? 8'h55 : 8'h50;
         bus.cfg_pattern = 4'b0101;
         bus.cfg_overlap = 1'b1;
         first = fr_acc.size();
         send_word(8'h55, 1'b0, 0, 1'b0);
         send_word(w2, 1'b1, 0, 1'b1);
         flush(10);
         build_expect(first, 4'b0101, 1'b1, d, h);
         for (int c = fr_acc[first] + 1; c <= d + 1; c++) begin
            n_chk++;
            if ({s_match[c], s_done[c], s_ready[c], s_busy[c]} !== {e_match[c], e_done[c], e_ready[c], ~e_ready[c]} ||
                (e_sv[c] && s_ser[c] !== e_ser[c]) ||
                s_cnt[c] !== exp_cnt(e_cnt[c]) || s2_cnt[c] !== exp_cnt2(e_cnt[c])) begin
               n_fail++;
               $display("FAIL wrap%0d cyc %0d: m/d/r/b/ser/cnt/cnt2 = %b %b %b %b %b %0d %0d, want %b %b %b %b %b %0d %0d",
                        v, c, s_match[c], s_done[c], s_ready[c], s_busy[c], s_ser[c], s_cnt[c], s2_cnt[c],
                        e_match[c], e_done[c], e_ready[c], ~e_ready[c], e_ser[c],
                        exp_cnt(e_cnt[c]), exp_cnt2(e_cnt[c]));
            end
         end
         n_chk++;
         if (s_cnt[d] !== ((v == 0) ? 8'd7 : 8'd5) || s2_cnt[d] !== exp_cnt2((v == 0) ? 7 : 5)) begin
            n_fail++;
            $display("FAIL wrap%0d_final: cnt=%0d cnt2=%0d, want cnt=%0d cnt2=%0d", v, s_cnt[d], s2_cnt[d],
                     (v == 0) ? 7 : 5, exp_cnt2((v == 0) ? 7 : 5));
         end
      end
   endtask

   task automatic test_random();
      int first, d, h, nw, hold;
      logic [3:0] pat;
      logic       ovl;
      for (int f = 0; f < 14; f++) begin
         pat = 4'($urandom);
         ovl = 1'($urandom);
         nw  = $urandom_range(1, 3);
         bus.cfg_pattern = pat;
         bus.cfg_overlap = ovl;
         first = fr_acc.size();
         for (int j = 0; j < nw; j++) begin
            hold = (j == 0) ? 0 : $urandom_range(0, 12);
            send_word(8'($urandom), (j == nw - 1) ? 1'b1 : 1'b0, hold, (j > 0) ? 1'b1 : 1'b0);
         end
         flush(10);
         build_expect(first, pat, ovl, d, h);
         for (int c = fr_acc[first] + 1; c <= d + 1; c++) begin
            n_chk++;
            if ({s_match[c], s_done[c], s_ready[c], s_busy[c]} !== {e_match[c], e_done[c], e_ready[c], ~e_ready[c]} ||
                (e_sv[c] && s_ser[c] !== e_ser[c]) ||
                s_cnt[c] !== exp_cnt(e_cnt[c]) || s2_cnt[c] !== exp_cnt2(e_cnt[c])) begin
               n_fail++;
               $display("FAIL random%0d cyc %0d: m/d/r/b/ser/cnt/cnt2 = %b %b %b %b %b %0d %0d, want %b %b %b %b %b %0d %0d",
                        f, c, s_match[c], s_done[c], s_ready[c], s_busy[c], s_ser[c], s_cnt[c], s2_cnt[c],
                        e_match[c], e_done[c], e_ready[c], ~e_ready[c], e_ser[c],
                        exp_cnt(e_cnt[c]), exp_cnt2(e_cnt[c]));
            end
         end
      end
   endtask

   initial begin
      reset           = 1'b0;
      bus.in_valid    = 1'b1;
      bus.in_word     = 8'h55;
      bus.in_last     = 1'b1;
      bus.cfg_pattern = 4'b0101;
      bus.cfg_overlap = 1'b1;
      test_reset();
      test_overlap();
      test_boundary_stall();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
